// File: rtl/mf_gate_unit_pkg.sv
// rtl/mf_gate_unit_pkg.sv - shared types and constants for the multi-function gate unit
package mf_gate_pkg;

  typedef enum logic [1:0] {SEL_AND, SEL_OR, SEL_XOR, SEL_NAND} mfg_sel_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DONE} mfg_state_t;

  localparam int SIG_W = 16;

endpackage

// File: rtl/mf_gate_unit_if.sv
// rtl/mf_gate_unit_if.sv - beat input / result output handshake bundle
interface mf_gate_unit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_x;
  logic [WIDTH-1:0] f_y;
  logic [1:0]       f_sel;

  modport master (
    output in_valid, x, y, sel, out_ready,
    input  in_ready, out_valid, f, f_x, f_y, f_sel
  );

  modport slave (
    input  in_valid, x, y, sel, out_ready,
    output in_ready, out_valid, f, f_x, f_y, f_sel
  );
endinterface

// File: rtl/mf_gate_unit_core.sv
// rtl/mf_gate_unit_core.sv - combinational WIDTH-bit bitwise function select
module mf_gate_core
  import mf_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  mfg_sel_t         sel_i,
  output logic [WIDTH-1:0] f_o
);

  always_comb begin
    f_o = '0;
    case (sel_i)
      SEL_AND:  f_o = x_i & y_i;
      SEL_OR:   f_o = x_i | y_i;
      SEL_XOR:  f_o = x_i ^ y_i;
      SEL_NAND: f_o = ~(x_i & y_i);
      default:  f_o = '0;
    endcase
  end

endmodule

// File: rtl/mf_gate_unit.sv
// rtl/mf_gate_unit.sv - pipelined bitwise gate unit with exhaustive self-sweep
// Optional output signature register enabled by MFG_SIGNATURE_EN.
module mf_gate_unit
  import mf_gate_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  mf_gate_unit_if.slave     bus,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [SIG_W-1:0]  sig
);

  localparam int CNT_W = 2*WIDTH + 2;
  localparam int LAST  = PIPE_DEPTH - 1;

  mfg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PIPE_DEPTH-1:0] vld_q;
  logic [WIDTH-1:0]      f_q   [PIPE_DEPTH];
  logic [WIDTH-1:0]      x_q   [PIPE_DEPTH];
  logic [WIDTH-1:0]      y_q   [PIPE_DEPTH];
  logic [1:0]            sel_q [PIPE_DEPTH];

  logic             adv;
  logic             in_ready;
  logic             src_vld;
  logic [WIDTH-1:0] src_x, src_y, src_f;
  logic [1:0]       src_sel;
  logic [WIDTH-1:0] sw_x, sw_y;
  logic [1:0]       sw_sel;

  assign adv = !vld_q[LAST] | bus.out_ready;
  assign {sw_x, sw_y, sw_sel} = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (adv) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (&cnt_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (vld_q == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A start pulse in IDLE/DONE takes priority over a concurrent external beat.
  always_comb begin
    sweep_busy = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    sweep_done = (state_q == ST_DONE);
    in_ready   = adv && ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !sweep_start;
    src_vld    = 1'b0;
    src_x      = bus.x;
    src_y      = bus.y;
    src_sel    = bus.sel;
    if (state_q == ST_SWEEP) begin
      src_vld = 1'b1;
      src_x   = sw_x;
      src_y   = sw_y;
      src_sel = sw_sel;
    end else if (state_q != ST_DRAIN) begin
      src_vld = bus.in_valid && in_ready;
    end
  end

  mf_gate_core #(.WIDTH(WIDTH)) u_core (
    .x_i   (src_x),
    .y_i   (src_y),
    .sel_i (mfg_sel_t'(src_sel)),
    .f_o   (src_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        f_q[i]   <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        sel_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= src_vld;
      f_q[0]   <= src_f;
      x_q[0]   <= src_x;
      y_q[0]   <= src_y;
      sel_q[0] <= src_sel;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        f_q[i]   <= f_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[LAST];
  assign bus.f         = f_q[LAST];
  assign bus.f_x       = x_q[LAST];
  assign bus.f_y       = y_q[LAST];
  assign bus.f_sel     = sel_q[LAST];

`ifdef MFG_SIGNATURE_EN
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (sweep_start) begin
      sig_d = '0;
    end else if (vld_q[LAST] && bus.out_ready) begin
      sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(f_q[LAST]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_mf_gate_unit.sv
// tb/tb_mf_gate_unit.sv - scoreboard bench for mf_gate_unit (WIDTH=1/PD=1 and WIDTH=4/PD=2 instances)
module tb_mf_gate_unit;

  typedef struct {
    logic [25:0] v;   // {x[7:0], y[7:0], sel[1:0], f[7:0]}
    int          t;   // expected output cycle, or -1 when untimed
  } exp_t;

  localparam int PD_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sweep_start_a = 1'b0, sweep_start_b = 1'b0;
  logic sweep_busy_a, sweep_busy_b, sweep_done_a, sweep_done_b;
  logic [15:0] sig_a, sig_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_a = 0, n_b = 0;
  logic [15:0] sig_ma = '0, sig_mb = '0;
  exp_t qa[$];
  exp_t qb[$];

  mf_gate_unit_if #(.WIDTH(1)) ifa ();
  mf_gate_unit_if #(.WIDTH(4)) ifb ();

  mf_gate_unit #(.WIDTH(1), .PIPE_DEPTH(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .sweep_start(sweep_start_a),
    .sweep_busy(sweep_busy_a), .sweep_done(sweep_done_a), .sig(sig_a)
  );

  mf_gate_unit #(.WIDTH(4), .PIPE_DEPTH(PD_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .sweep_start(sweep_start_b),
    .sweep_busy(sweep_busy_b), .sweep_done(sweep_done_b), .sig(sig_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] fm(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s);
    case (s)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  function automatic logic [15:0] rot_xor(input logic [15:0] s, input logic [7:0] f);
    return {s[14:0], s[15]} ^ {8'h00, f};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      n_a++;
      if (qa.size() == 0) begin
        chk("a_unexpected_beat", {ifa.f_x, ifa.f_y, ifa.f_sel, ifa.f}, 0);
      end else begin
        e = qa.pop_front();
        chk("a_beat", {8'(ifa.f_x), 8'(ifa.f_y), ifa.f_sel, 8'(ifa.f)}, e.v);
        sig_ma = rot_xor(sig_ma, e.v[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      n_b++;
      if (qb.size() == 0) begin
        chk("b_unexpected_beat", {ifb.f_x, ifb.f_y, ifb.f_sel, ifb.f}, 0);
      end else begin
        e = qb.pop_front();
        chk("b_beat", {8'(ifb.f_x), 8'(ifb.f_y), ifb.f_sel, 8'(ifb.f)}, e.v);
        if (e.t >= 0) chk("b_latency", cyc, e.t);
        sig_mb = rot_xor(sig_mb, e.v[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit b, input int budget, input string nm);
    int n = 0;
    while (!(b ? sweep_done_b : sweep_done_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < budget, 1);
  endtask

  task automatic send_b(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s,
                        input logic [3:0] fexp, input bit timed);
    exp_t e;
    int   n = 0;
    bit   acc = 1'b0;
    ifb.x = x;
    ifb.y = y;
    ifb.sel = s;
    ifb.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ifb.in_ready;
      if (acc) begin
        e.v = {4'h0, x, 4'h0, y, s, 4'h0, fexp};
        e.t = timed ? cyc + PD_B : -1;
        qb.push_back(e);
      end
      tick();
      n++;
    end
    ifb.in_valid = 1'b0;
    if (!acc) chk("b_send_timeout", 0, 1);
  endtask

  task automatic push_sweep_b();
    exp_t e;
    logic [9:0] c;
    for (int i = 0; i < 1024; i++) begin
      c = 10'(i);
      e.v = {4'h0, c[9:6], 4'h0, c[5:2], c[1:0], 4'h0, fm(c[9:6], c[5:2], c[1:0])};
      e.t = -1;
      qb.push_back(e);
    end
  endtask

  function automatic logic [15:0] exp_sig(input logic [15:0] model);
`ifdef MFG_SIGNATURE_EN
    return model;
`else
    return model & 16'h0000;
`endif
  endfunction

  initial begin
    exp_t        e;
    logic [15:0] tt;
    logic [3:0]  c4;
    logic [25:0] held;
    int          nb0;

    ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.sel = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.sel = '0; ifb.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_out_valid", ifa.out_valid, 0);
    chk("rst_a_f", ifa.f, 0);
    chk("rst_b_out_valid", ifb.out_valid, 0);
    chk("rst_b_fields", {ifb.f, ifb.f_x, ifb.f_y, ifb.f_sel}, 0);
    chk("rst_b_busy", sweep_busy_b, 0);
    chk("rst_b_done", sweep_done_b, 0);
    chk("rst_b_sig", sig_b, 0);
    chk("rst_b_in_ready", ifb.in_ready, 1);
    tick();

    // WIDTH=1 exhaustive sweep against a hand-built truth table
    tt = 16'h3EE8;
    for (int i = 0; i < 16; i++) begin
      c4 = 4'(i);
      e.v = {7'h0, c4[3], 7'h0, c4[2], c4[1:0], 7'h0, tt[i]};
      e.t = -1;
      qa.push_back(e);
    end
    sig_ma = '0;
    n_a = 0;
    sweep_start_a = 1'b1;
    tick();
    sweep_start_a = 1'b0;
    chk("a_busy_in_sweep", sweep_busy_a, 1);
    wait_done(1'b0, 100, "a_sweep_done_timeout");
    chk("a_result_count", n_a, 16);
    chk("a_queue_empty", qa.size(), 0);
    chk("a_busy_after_done", sweep_busy_a, 0);
    chk("a_sig", sig_a, exp_sig(sig_ma));
    repeat (3) tick();
    chk("a_done_sticky", sweep_done_a, 1);

    // External beat C,A,XOR -> 6 with PIPE_DEPTH latency
    send_b(4'hC, 4'hA, 2'b10, 4'h6, 1'b1);
    repeat (4) tick();
    chk("b_single_drained", qb.size(), 0);

    // Stream with a 5-cycle downstream stall
    nb0 = n_b;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_b(4'(i), 4'(15 - i), 2'(i), fm(4'(i), 4'(15 - i), 2'(i)), 1'b0);
      end
      begin
        repeat (4) tick();
        ifb.out_ready = 1'b0;
        @(negedge clk);
        held = {8'(ifb.f_x), 8'(ifb.f_y), ifb.f_sel, 8'(ifb.f)};
        chk("stall_out_valid", ifb.out_valid, 1);
        chk("stall_in_ready", ifb.in_ready, 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_hold", {8'(ifb.f_x), 8'(ifb.f_y), ifb.f_sel, 8'(ifb.f)}, held);
          chk("stall_in_ready", ifb.in_ready, 0);
        end
        tick();
        ifb.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && qb.size() != 0; k++) tick();
    chk("stream_queue_empty", qb.size(), 0);
    chk("stream_count", n_b - nb0, 12);

    // Reset in the middle of a WIDTH=4 sweep
    push_sweep_b();
    sig_mb = '0;
    sweep_start_b = 1'b1;
    tick();
    sweep_start_b = 1'b0;
    repeat (37) tick();
    rst = 1'b1;
    sig_ma = '0;
    sig_mb = '0;
    tick();
    rst = 1'b0;
    qb.delete();
    @(negedge clk);
    chk("midrst_out_valid", ifb.out_valid, 0);
    chk("midrst_busy", sweep_busy_b, 0);
    chk("midrst_done", sweep_done_b, 0);
    tick();

    // Restarted sweep runs from cnt=0 to completion
    push_sweep_b();
    nb0 = n_b;
    sweep_start_b = 1'b1;
    tick();
    sweep_start_b = 1'b0;
    wait_done(1'b1, 1200, "b_restart_done_timeout");
    chk("b_restart_count", n_b - nb0, 1024);
    chk("b_restart_queue_empty", qb.size(), 0);
    chk("b_restart_sig", sig_b, exp_sig(sig_mb));

    // sweep_start and in_valid together in IDLE: the sweep wins
    rst = 1'b1;
    sig_ma = '0;
    sig_mb = '0;
    tick();
    rst = 1'b0;
    tick();
    push_sweep_b();
    nb0 = n_b;
    ifb.x = 4'hF; ifb.y = 4'hF; ifb.sel = 2'b11;
    ifb.in_valid = 1'b1;
    sweep_start_b = 1'b1;
    @(negedge clk);
    chk("start_beats_in_ready", ifb.in_ready, 0);
    tick();
    sweep_start_b = 1'b0;
    ifb.in_valid = 1'b0;
    wait_done(1'b1, 1200, "b_sweep2_done_timeout");
    chk("b_sweep2_count", n_b - nb0, 1024);
    chk("b_sweep2_queue_empty", qb.size(), 0);
    chk("b_sweep2_sig", sig_b, exp_sig(sig_mb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout act=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
